// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } state_e;

  // Pipeline register indices, oldest-fetch first.
  localparam int unsigned PC         = 0;
  localparam int unsigned PF_IF      = 1;
  localparam int unsigned IF_ID      = 2;
  localparam int unsigned ID_EX      = 3;
  localparam int unsigned EX_MEM1    = 4;
  localparam int unsigned MEM1_MEM2  = 5;
  localparam int unsigned MEM2_WB    = 6;
  localparam int unsigned NUM_STAGES = 7;

  localparam int unsigned DIV_CYCLES_DEF = 33;

endpackage

// File: rtl/pipe_ctrl_div_busy_cnt.sv
// Divider occupancy counter: loads on an accepted start, counts down to zero.
module div_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic clear_i,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle;

  always_comb begin
    idle   = (cnt_q == '0);
    // A start seen while already counting is ignored; busy covers the accept cycle.
    busy_o = ~idle | start_i;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i && idle) begin
      cnt_d = LoadVal;
    end else if (idle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 7-register pipeline, with divider
// occupancy tracking and an icache drop state for refills made stale by a redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic icache_stall,
  input  logic load_use,
  input  logic div_start,
  input  logic bp_flush,
  input  logic exc_flush,
  input  logic dcache_stall,
  output logic pc_wr,
  output logic pf_if_wr,
  output logic if_id_wr,
  output logic id_ex_wr,
  output logic ex_mem1_wr,
  output logic mem1_mem2_wr,
  output logic mem2_wb_wr,
  output logic pf_if_flush,
  output logic if_flush,
  output logic id_flush,
  output logic ex_flush,
  output logic mem1_flush,
  output logic mem2_flush,
  output logic redir_exc,
  output logic redir_bp,
  output logic div_busy
);

  state_e                  state_q, state_d;
  logic [NUM_STAGES-1:0]   wr;
  logic [NUM_STAGES-1:1]   fl;
  logic                    busy, exc_take, bp_take;

  div_busy_cnt #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_cnt (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .clear_i (exc_take),
    .busy_o  (busy)
  );

  always_comb begin
    wr        = '1;
    fl        = '0;
    redir_exc = 1'b0;
    redir_bp  = 1'b0;
    exc_take  = exc_flush & ~dcache_stall;
    bp_take   = bp_flush & ~dcache_stall & ~exc_flush & ~busy;

    if (dcache_stall) begin
      wr          = '0;
      fl[MEM2_WB] = 1'b1;
    end else if (exc_flush) begin
      redir_exc             = 1'b1;
      fl[MEM1_MEM2:PF_IF]   = '1;
    end else if (busy) begin
      wr[ID_EX:PC] = '0;
      fl[EX_MEM1]  = 1'b1;
    end else if (bp_flush) begin
      redir_bp   = 1'b1;
      fl[PF_IF]  = 1'b1;
      fl[IF_ID]  = 1'b1;
    end else if (load_use) begin
      wr[IF_ID:PC] = '0;
      fl[ID_EX]    = 1'b1;
    end else if (icache_stall) begin
      wr[PF_IF:PC] = '0;
      fl[IF_ID]    = 1'b1;
    end

    // Discard the stale refill; only bubble IF_ID when it is actually advancing.
    if (state_q == ST_DROP) begin
      wr[PC]    = exc_take | bp_take;
      wr[PF_IF] = 1'b0;
      fl[IF_ID] = fl[IF_ID] | wr[IF_ID];
    end

    unique case (state_q)
      ST_RUN:  state_d = ((exc_take | bp_take) && icache_stall) ? ST_DROP : ST_RUN;
      ST_DROP: state_d = icache_stall ? ST_DROP : ST_RUN;
      default: state_d = ST_RUN;
    endcase

    if (rst) begin
      wr        = '0;
      fl        = '1;
      redir_exc = 1'b0;
      redir_bp  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_wr        = wr[PC];
  assign pf_if_wr     = wr[PF_IF];
  assign if_id_wr     = wr[IF_ID];
  assign id_ex_wr     = wr[ID_EX];
  assign ex_mem1_wr   = wr[EX_MEM1];
  assign mem1_mem2_wr = wr[MEM1_MEM2];
  assign mem2_wb_wr   = wr[MEM2_WB];
  assign pf_if_flush  = fl[PF_IF];
  assign if_flush     = fl[IF_ID];
  assign id_flush     = fl[ID_EX];
  assign ex_flush     = fl[EX_MEM1];
  assign mem1_flush   = fl[MEM1_MEM2];
  assign mem2_flush   = fl[MEM2_WB];
  assign div_busy     = busy & ~rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, redirects, drop state and divider timing.
module tb_pipe_ctrl;

  localparam int unsigned DivCycles = 12;

  logic clk = 1'b0;
  logic rst;
  logic icache_stall, load_use, div_start, bp_flush, exc_flush, dcache_stall;
  logic pc_wr, pf_if_wr, if_id_wr, id_ex_wr, ex_mem1_wr, mem1_mem2_wr, mem2_wb_wr;
  logic pf_if_flush, if_flush, id_flush, ex_flush, mem1_flush, mem2_flush;
  logic redir_exc, redir_bp, div_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] obs;
  // {wr pc..mem2_wb, flush pf_if..mem2, redir_exc, redir_bp, div_busy}
  assign obs = {pc_wr, pf_if_wr, if_id_wr, id_ex_wr, ex_mem1_wr, mem1_mem2_wr, mem2_wb_wr,
                pf_if_flush, if_flush, id_flush, ex_flush, mem1_flush, mem2_flush,
                redir_exc, redir_bp, div_busy};

  localparam logic [15:0] Idle = {7'b1111111, 6'b000000, 3'b000};
  localparam logic [15:0] Rst  = {7'b0000000, 6'b111111, 3'b000};
  localparam logic [15:0] Div  = {7'b0000111, 6'b000100, 3'b001};
  localparam logic [15:0] Drop = {7'b0011111, 6'b010000, 3'b000};

  pipe_ctrl #(
    .DIV_CYCLES (DivCycles),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_stall (icache_stall),
    .load_use     (load_use),
    .div_start    (div_start),
    .bp_flush     (bp_flush),
    .exc_flush    (exc_flush),
    .dcache_stall (dcache_stall),
    .pc_wr        (pc_wr),
    .pf_if_wr     (pf_if_wr),
    .if_id_wr     (if_id_wr),
    .id_ex_wr     (id_ex_wr),
    .ex_mem1_wr   (ex_mem1_wr),
    .mem1_mem2_wr (mem1_mem2_wr),
    .mem2_wb_wr   (mem2_wb_wr),
    .pf_if_flush  (pf_if_flush),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .ex_flush     (ex_flush),
    .mem1_flush   (mem1_flush),
    .mem2_flush   (mem2_flush),
    .redir_exc    (redir_exc),
    .redir_bp     (redir_bp),
    .div_busy     (div_busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic ic, input logic lu, input logic ds, input logic bp,
                       input logic ex, input logic dc);
    icache_stall = ic;
    load_use     = lu;
    div_start    = ds;
    bp_flush     = bp;
    exc_flush    = ex;
    dcache_stall = dc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    checks++;
    if (obs !== Rst) begin
      errors++; $display("FAIL reset_outputs got %b want %b", obs, Rst);
    end
    drive(1, 1, 1, 1, 1, 1);
    checks++;
    if (obs !== Rst) begin
      errors++; $display("FAIL reset_with_requests got %b want %b", obs, Rst);
    end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== Idle) begin
        errors++; $display("FAIL idle[%0d] got %b want %b", i, obs, Idle);
      end
      tick();
    end
  endtask

  task automatic test_div();
    for (int i = 0; i < int'(DivCycles); i++) begin
      drive(0, 0, i == 0, 0, 0, 0);
      checks++;
      if (obs !== Div) begin
        errors++; $display("FAIL div_stall[%0d] got %b want %b", i, obs, Div);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== Idle) begin
      errors++; $display("FAIL div_release got %b want %b", obs, Idle);
    end
    tick();
  endtask

  task automatic test_exc_during_dcache();
    logic [15:0] exp_dc, exp_ex;
    exp_dc = {7'b0000000, 6'b000001, 3'b000};
    exp_ex = {7'b1111111, 6'b111110, 3'b100};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 1);
      checks++;
      if (obs !== exp_dc) begin
        errors++; $display("FAIL exc_dcache_hold[%0d] got %b want %b", i, obs, exp_dc);
      end
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if (obs !== exp_ex) begin
      errors++; $display("FAIL exc_after_dcache got %b want %b", obs, exp_ex);
    end
    tick();
  endtask

  task automatic test_bp_drop();
    logic [15:0] exp_bp;
    exp_bp = {7'b1111111, 6'b110000, 3'b010};
    drive(1, 0, 0, 1, 0, 0);
    checks++;
    if (obs !== exp_bp) begin
      errors++; $display("FAIL bp_icache got %b want %b", obs, exp_bp);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== Drop) begin
        errors++; $display("FAIL drop[%0d] got %b want %b", i, obs, Drop);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== Idle) begin
      errors++; $display("FAIL drop_exit got %b want %b", obs, Idle);
    end
    tick();
  endtask

  task automatic test_redirect_in_drop();
    logic [15:0] exp_ex, exp_ex_drop;
    exp_ex      = {7'b1111111, 6'b111110, 3'b100};
    exp_ex_drop = {7'b1011111, 6'b111110, 3'b100};
    drive(1, 0, 0, 0, 1, 0);
    checks++;
    if (obs !== exp_ex) begin
      errors++; $display("FAIL exc_icache got %b want %b", obs, exp_ex);
    end
    tick();
    drive(1, 0, 0, 0, 1, 0);
    checks++;
    if (obs !== exp_ex_drop) begin
      errors++; $display("FAIL exc_in_drop got %b want %b", obs, exp_ex_drop);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== Drop) begin
      errors++; $display("FAIL drop_refill got %b want %b", obs, Drop);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== Idle) begin
      errors++; $display("FAIL drop_resume got %b want %b", obs, Idle);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_lu, exp_exbp, exp_bplu, exp_ic;
    exp_lu   = {7'b0001111, 6'b001000, 3'b000};
    exp_exbp = {7'b1111111, 6'b111110, 3'b100};
    exp_bplu = {7'b1111111, 6'b110000, 3'b010};
    exp_ic   = {7'b0011111, 6'b010000, 3'b000};
    drive(1, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_lu) begin
      errors++; $display("FAIL load_use_icache got %b want %b", obs, exp_lu);
    end
    tick();
    drive(0, 0, 0, 1, 1, 0);
    checks++;
    if (obs !== exp_exbp) begin
      errors++; $display("FAIL exc_and_bp got %b want %b", obs, exp_exbp);
    end
    tick();
    drive(0, 1, 0, 1, 0, 0);
    checks++;
    if (obs !== exp_bplu) begin
      errors++; $display("FAIL bp_and_load_use got %b want %b", obs, exp_bplu);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_ic) begin
      errors++; $display("FAIL icache_only got %b want %b", obs, exp_ic);
    end
    tick();
  endtask

  task automatic test_exc_during_div();
    logic [15:0] exp_ex;
    exp_ex = {7'b1111111, 6'b111110, 3'b101};
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, i == 0, 0, 0, 0);
      checks++;
      if (obs !== Div) begin
        errors++; $display("FAIL exc_div_pre[%0d] got %b want %b", i, obs, Div);
      end
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if (obs !== exp_ex) begin
      errors++; $display("FAIL exc_div_cycle got %b want %b", obs, exp_ex);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== Idle) begin
      errors++; $display("FAIL exc_div_cleared got %b want %b", obs, Idle);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== Rst) begin
      errors++; $display("FAIL reset_mid_div got %b want %b", obs, Rst);
    end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== Idle) begin
      errors++; $display("FAIL after_reset_mid_div got %b want %b", obs, Idle);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_div();
    test_exc_during_dcache();
    test_bp_drop();
    test_redirect_in_drop();
    test_simultaneous();
    test_exc_during_div();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
